tt_zbuf_seq: RTL and testbench

TT_ZBUF_SEQ -- requirements
Module: tt_zbuf_seq

---
 rtl/tt_zbuf_seq.sv | 123 ++++++++++++
 tb/tb_tt_zbuf_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_zbuf_seq.sv
// Break-before-make sequencer for a bank of zeroing-buffer enables.
// Ports: clk, rst (async high); req_valid/req_ready/req_sel/req_off
// request handshake; zbuf_e one-hot/zero enables; cur_sel/cur_vld
// active index when settled; busy while breaking or making.
module tt_zbuf_seq #(
  parameter int N_OUT         = 4,
  parameter int SEL_W         = 2,
  parameter int DEAD_CYCLES   = 8,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SEL_W-1:0] req_sel,
  input  logic             req_off,
  output logic [N_OUT-1:0] zbuf_e,
  output logic [SEL_W-1:0] cur_sel,
  output logic             cur_vld,
  output logic             busy
);

  localparam int MAXC  = (DEAD_CYCLES > SETTLE_CYCLES) ?
                         DEAD_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  localparam logic [CNT_W-1:0] DEAD_LD   = CNT_W'(DEAD_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  typedef enum logic [1:0] {
    S_OFF,
    S_BREAK,
    S_MAKE,
    S_ON
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] tgt;
  logic             tgt_off;
  logic             is_off;
  logic             is_same;

  function automatic logic [N_OUT-1:0] dec(input logic [SEL_W-1:0] s);
    logic [N_OUT-1:0] d;
    d = '0;
    for (int i = 0; i < N_OUT; i++)
      d[i] = (s == SEL_W'(i));
    return d;
  endfunction

  // Out-of-range indices are folded into the off path so they can
  // never reach the enable decode.
  assign is_off  = req_off || (int'(req_sel) >= N_OUT);
  assign is_same = !is_off && (req_sel == tgt);

  assign req_ready = (state == S_OFF) || (state == S_ON);
  assign busy      = (state == S_BREAK) || (state == S_MAKE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_OFF;
      cnt     <= '0;
      tgt     <= '0;
      tgt_off <= 1'b0;
      zbuf_e  <= '0;
      cur_sel <= '0;
      cur_vld <= 1'b0;
    end else begin
      unique case (state)
        S_OFF: begin
          // Nothing is driven, so a make needs no dead interval.
          if (req_valid && !is_off) begin
            tgt     <= req_sel;
            tgt_off <= 1'b0;
            cnt     <= SETTLE_LD;
            zbuf_e  <= dec(req_sel);
            state   <= S_MAKE;
          end
        end
        S_ON: begin
          if (req_valid && !is_same) begin
            tgt     <= is_off ? '0 : req_sel;
            tgt_off <= is_off;
            cnt     <= DEAD_LD;
            zbuf_e  <= '0;
            cur_sel <= '0;
            cur_vld <= 1'b0;
            state   <= S_BREAK;
          end
        end
        S_BREAK: begin
          if (cnt == ONE) begin
            if (tgt_off) begin
              tgt_off <= 1'b0;
              cnt     <= '0;
              state   <= S_OFF;
            end else begin
              cnt    <= SETTLE_LD;
              zbuf_e <= dec(tgt);
              state  <= S_MAKE;
            end
          end else begin
            cnt <= cnt - ONE;
          end
        end
        S_MAKE: begin
          if (cnt == ONE) begin
            cnt     <= '0;
            cur_sel <= tgt;
            cur_vld <= 1'b1;
            state   <= S_ON;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        default: state <= S_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_zbuf_seq.sv
// Bench for tt_zbuf_seq: scoreboarded request sequences, a 3-output
// instance for out-of-range selects, reset abandon and random stream.
module tb_tt_zbuf_seq;

  localparam int DEAD   = 8;
  localparam int SETTLE = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_sel;
  logic       req_off;
  logic [3:0] zbuf_e;
  logic [1:0] cur_sel;
  logic       cur_vld;
  logic       busy;

  logic       v2;
  logic       rdy2;
  logic [1:0] sel2;
  logic       off2;
  logic [2:0] zb2;
  logic [1:0] cs2;
  logic       vld2;
  logic       busy2;

  int checks = 0;
  int errors = 0;

  logic [8:0] sb[$];
  logic       m_on;
  logic [1:0] m_idx;

  int last_idx;
  int zrun;

  tt_zbuf_seq #(
    .N_OUT(4), .SEL_W(2),
    .DEAD_CYCLES(DEAD), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_off(req_off),
    .zbuf_e(zbuf_e), .cur_sel(cur_sel),
    .cur_vld(cur_vld), .busy(busy)
  );

  tt_zbuf_seq #(
    .N_OUT(3), .SEL_W(2),
    .DEAD_CYCLES(2), .SETTLE_CYCLES(3)
  ) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(v2), .req_ready(rdy2),
    .req_sel(sel2), .req_off(off2),
    .zbuf_e(zb2), .cur_sel(cs2),
    .cur_vld(vld2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] oh(input logic [1:0] s);
    logic [3:0] o;
    o = 4'b0001 << s;
    return o;
  endfunction

  // {ready, busy, vld, cur_sel, zbuf_e}
  function automatic logic [8:0] ev(input logic r, input logic b,
                                    input logic v, input logic [1:0] c,
                                    input logic [3:0] z);
    return {r, b, v, c, z};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      last_idx = -1;
      zrun     = 0;
    end else begin
      chk("onehot", 32'($onehot0(zbuf_e)), 1);
      chk("onehot3", 32'($onehot0(zb2)), 1);
      if (zbuf_e == 4'b0) begin
        zrun++;
      end else begin
        int idx;
        idx = 0;
        for (int i = 0; i < 4; i++)
          if (zbuf_e[i]) idx = i;
        if (last_idx >= 0 && idx != last_idx)
          chk("dead_gap", 32'(zrun >= DEAD), 1);
        last_idx = idx;
        zrun     = 0;
      end
    end
  end

  task automatic do_req(input logic [1:0] s, input logic off);
    logic [8:0] e;
    req_sel   = s;
    req_off   = off;
    req_valid = 1'b1;
    chk("ready_pre", 32'(req_ready), 1);
    if (!m_on) begin
      if (off) begin
        sb.push_back(ev(1, 0, 0, 0, 0));
      end else begin
        repeat (SETTLE) sb.push_back(ev(0, 1, 0, 0, oh(s)));
        sb.push_back(ev(1, 0, 1, s, oh(s)));
        m_on  = 1'b1;
        m_idx = s;
      end
    end else if (!off && s == m_idx) begin
      sb.push_back(ev(1, 0, 1, m_idx, oh(m_idx)));
    end else begin
      repeat (DEAD) sb.push_back(ev(0, 1, 0, 0, 0));
      if (off) begin
        sb.push_back(ev(1, 0, 0, 0, 0));
        m_on = 1'b0;
      end else begin
        repeat (SETTLE) sb.push_back(ev(0, 1, 0, 0, oh(s)));
        sb.push_back(ev(1, 0, 1, s, oh(s)));
        m_idx = s;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk("seq", {23'b0, req_ready, busy, cur_vld, cur_sel, zbuf_e},
          {23'b0, e});
      if (sb.size() > 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_sel   = '0;
    req_off   = 1'b0;
    v2        = 1'b0;
    sel2      = '0;
    off2      = 1'b0;
    m_on      = 1'b0;
    m_idx     = '0;
    #1;
    chk("rst_z", 32'(zbuf_e), 0);
    chk("rst_vld", 32'(cur_vld), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sel", 32'(cur_sel), 0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_ready", 32'(req_ready), 1);
    chk("rel_z", 32'(zbuf_e), 0);

    do_req(2'd2, 1'b0);
    do_req(2'd1, 1'b0);
    do_req(2'd0, 1'b1);
    do_req(2'd3, 1'b0);
    do_req(2'd3, 1'b0);
    do_req(2'd0, 1'b1);
    do_req(2'd2, 1'b1);

    sel2 = 2'd3;
    v2   = 1'b1;
    @(posedge clk);
    #1;
    v2 = 1'b0;
    chk("n3_off_z", 32'(zb2), 0);
    chk("n3_off_rdy", 32'(rdy2), 1);
    chk("n3_off_busy", 32'(busy2), 0);
    sel2 = 2'd1;
    v2   = 1'b1;
    @(posedge clk);
    #1;
    v2 = 1'b0;
    chk("n3_make_z", 32'(zb2), 32'h2);
    chk("n3_make_busy", 32'(busy2), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("n3_on_vld", 32'(vld2), 1);
    chk("n3_on_sel", 32'(cs2), 1);
    sel2 = 2'd3;
    v2   = 1'b1;
    @(posedge clk);
    #1;
    v2 = 1'b0;
    chk("n3_brk_z", 32'(zb2), 0);
    chk("n3_brk_busy", 32'(busy2), 1);
    repeat (2) @(posedge clk);
    #1;
    chk("n3_end_busy", 32'(busy2), 0);
    chk("n3_end_vld", 32'(vld2), 0);
    chk("n3_end_rdy", 32'(rdy2), 1);
    chk("n3_end_z", 32'(zb2), 0);

    req_sel   = 2'd0;
    req_off   = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("mk_z", 32'(zbuf_e), 1);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_z", 32'(zbuf_e), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_vld", 32'(cur_vld), 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    m_on = 1'b0;
    repeat (SETTLE + 4) begin
      @(posedge clk);
      #1;
      chk("post_rst_z", 32'(zbuf_e), 0);
    end
    chk("post_rst_rdy", 32'(req_ready), 1);

    for (int k = 0; k < 40; k++) begin
      logic [1:0] s;
      logic       o;
      s = 2'($urandom_range(0, 3));
      o = ($urandom_range(0, 4) == 0);
      do_req(s, o);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
